image_streamer: RTL and testbench

- Upstream feeder for regnet. Collects one image, one pixel per handshake, from a serial source (UART/DMA bridge) into a local buffer.
- Once the buffer is full, streams the image into regnet as INPUT_SIZE pixels per cycle, with image_ready held high for the whole burst.
- Then blocks until regnet raises label_ready before accepting the next image.

---
 rtl/image_streamer_pkg.sv | 24 ++
 rtl/image_streamer_buffer.sv | 49 ++++
 rtl/image_streamer.sv | 154 +++++++++++++++
 tb/tb_image_streamer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_streamer_pkg.sv
// Shared fixed-point pixel definitions and streamer FSM encoding.
// The pixel format (INTEGER_WIDTH/FRACTION_WIDTH) matches the one regnet uses.
package image_streamer_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int PIXEL_WIDTH    = INTEGER_WIDTH + FRACTION_WIDTH;

  // Signed fixed-point pixel; bit PIXEL_WIDTH-1 is the sign, the low
  // FRACTION_WIDTH bits are the fraction.
  typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    STREAM     = 2'd1,
    WAIT_LABEL = 2'd2
  } streamer_state_e;

  // Integer ceiling division for chunk counts.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/image_streamer_buffer.sv
// image_buffer: NUM_PIXELS-deep pixel store with one write port and an
// INPUT_SIZE-wide chunk read port. Lanes past the last pixel read as zero.
module image_buffer
  import image_streamer_pkg::*;
#(
  parameter int NUM_PIXELS = 10,
  parameter int INPUT_SIZE = 1,
  parameter int NUM_CHUNKS = ceil_div(NUM_PIXELS, INPUT_SIZE),
  parameter int ADDR_W     = $clog2(NUM_PIXELS + 1),
  parameter int CHUNK_W    = $clog2(NUM_CHUNKS + 1)
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  pixel_t             wr_data,
  input  logic [CHUNK_W-1:0] rd_chunk,
  output pixel_t             rd_pixels [INPUT_SIZE]
);

  pixel_t mem    [NUM_PIXELS];
  pixel_t padded [NUM_CHUNKS][INPUT_SIZE];
  logic [CHUNK_W-1:0] rd_sel;

  // Pixel store; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Chunk-ordered view of the store with the zero padding fixed at elaboration.
  for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
    for (genvar l = 0; l < INPUT_SIZE; l++) begin : g_lane
      if (c * INPUT_SIZE + l < NUM_PIXELS) begin : g_real
        assign padded[c][l] = mem[c*INPUT_SIZE+l];
      end else begin : g_pad
        assign padded[c][l] = '0;
      end
    end
  end

  // The controller only consumes data for chunk indices below NUM_CHUNKS;
  // clamp so the terminal count never reads outside the array.
  assign rd_sel = (rd_chunk < CHUNK_W'(NUM_CHUNKS)) ? rd_chunk : '0;

  // Chunk read mux.
  always_comb begin
    for (int i = 0; i < INPUT_SIZE; i++) rd_pixels[i] = padded[rd_sel][i];
  end

endmodule

// File: rtl/image_streamer.sv
// image_streamer: loads one image pixel-by-pixel, streams it to regnet as
// INPUT_SIZE-pixel chunks, then waits for label_ready before the next image.
// Optional build macro IMAGE_STREAMER_TIMEOUT_EN adds a WAIT_LABEL watchdog
// and a one-cycle timeout output.
//
// Handshake: a pixel is transferred on a rising clock edge where both
// in_valid and in_ready are high. in_ready is a registered output that does
// not depend on in_valid; in_valid/in_pixel seen while in_ready is low are
// ignored and nothing is stored. The image output side has no backpressure:
// image_ready marks each valid chunk on pixels for exactly one cycle.
module image_streamer
  import image_streamer_pkg::*;
#(
  parameter int NUM_PIXELS     = 10,
  parameter int INPUT_SIZE     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  pixel_t          in_pixel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            label_ready,
  output logic            image_ready,
  output pixel_t          pixels [INPUT_SIZE],
  output logic            busy,
`ifdef IMAGE_STREAMER_TIMEOUT_EN
  output logic            timeout,
`endif
  output streamer_state_e state_dbg
);

  localparam int NUM_CHUNKS = ceil_div(NUM_PIXELS, INPUT_SIZE);
  localparam int LOAD_W     = $clog2(NUM_PIXELS + 1);
  localparam int CHUNK_W    = $clog2(NUM_CHUNKS + 1);

  if (NUM_PIXELS < 1 || INPUT_SIZE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("image_streamer: NUM_PIXELS, INPUT_SIZE and TIMEOUT_CYCLES must be >= 1");
  end

  streamer_state_e    state, state_nxt;
  logic [LOAD_W-1:0]  load_cnt, load_cnt_nxt;
  logic [CHUNK_W-1:0] chunk_cnt, chunk_cnt_nxt;
  logic               image_ready_nxt;
  pixel_t             pixels_nxt [INPUT_SIZE];
  pixel_t             chunk_data [INPUT_SIZE];
  logic               wr_en;

`ifdef IMAGE_STREAMER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic            timeout_nxt;
`endif

  image_buffer #(
    .NUM_PIXELS (NUM_PIXELS),
    .INPUT_SIZE (INPUT_SIZE)
  ) u_buffer (
    .clock     (clock),
    .wr_en     (wr_en),
    .wr_addr   (load_cnt),
    .wr_data   (in_pixel),
    .rd_chunk  (chunk_cnt),
    .rd_pixels (chunk_data)
  );

  assign busy      = (state != LOAD);
  assign state_dbg = state;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_nxt       = state;
    load_cnt_nxt    = load_cnt;
    chunk_cnt_nxt   = chunk_cnt;
    image_ready_nxt = 1'b0;
    wr_en           = 1'b0;
    for (int i = 0; i < INPUT_SIZE; i++) pixels_nxt[i] = '0;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
    wd_cnt_nxt  = '0;
    timeout_nxt = 1'b0;
`endif
    case (state)
      LOAD: begin
        if (in_valid && in_ready) begin
          wr_en = 1'b1;
          if (load_cnt == LOAD_W'(NUM_PIXELS - 1)) begin
            load_cnt_nxt = '0;
            state_nxt    = STREAM;
          end else begin
            load_cnt_nxt = load_cnt + 1'b1;
          end
        end
      end
      STREAM: begin
        // One chunk per cycle; the extra terminal cycle clears the outputs.
        if (chunk_cnt < CHUNK_W'(NUM_CHUNKS)) begin
          image_ready_nxt = 1'b1;
          for (int i = 0; i < INPUT_SIZE; i++) pixels_nxt[i] = chunk_data[i];
          chunk_cnt_nxt = chunk_cnt + 1'b1;
        end else begin
          chunk_cnt_nxt = '0;
          state_nxt     = WAIT_LABEL;
        end
      end
      WAIT_LABEL: begin
        if (label_ready) begin
          state_nxt = LOAD;
        end
`ifdef IMAGE_STREAMER_TIMEOUT_EN
        else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt   = LOAD;
          timeout_nxt = 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= LOAD;
      load_cnt    <= '0;
      chunk_cnt   <= '0;
      in_ready    <= 1'b0;
      image_ready <= 1'b0;
      for (int i = 0; i < INPUT_SIZE; i++) pixels[i] <= '0;
    end else begin
      state       <= state_nxt;
      load_cnt    <= load_cnt_nxt;
      chunk_cnt   <= chunk_cnt_nxt;
      in_ready    <= (state_nxt == LOAD);
      image_ready <= image_ready_nxt;
      for (int i = 0; i < INPUT_SIZE; i++) pixels[i] <= pixels_nxt[i];
    end
  end

`ifdef IMAGE_STREAMER_TIMEOUT_EN
  // Watchdog counter (cleared outside WAIT_LABEL) and timeout pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      wd_cnt  <= wd_cnt_nxt;
      timeout <= timeout_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_image_streamer.sv
// Bench for image_streamer: one instance with INPUT_SIZE=1 (index 0) and one
// with INPUT_SIZE=4 (index 1, padded final chunk), sharing clock and reset.
`timescale 1ns/1ps
module tb_image_streamer;
  import image_streamer_pkg::*;

  localparam int NP   = 10;
  localparam int W    = PIXEL_WIDTH;
  localparam int MAXL = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  pixel_t          in_pixel_v    [2];
  logic            in_valid_v    [2];
  logic            label_ready_v [2];
  logic            in_ready_v    [2];
  logic            image_ready_v [2];
  logic            busy_v        [2];
  streamer_state_e state_v       [2];
  pixel_t          pix_a [1];
  pixel_t          pix_b [4];
`ifdef IMAGE_STREAMER_TIMEOUT_EN
  logic            timeout_v [2];
`endif

  int checks   = 0;
  int failures = 0;
  logic [MAXL*W-1:0] exp_q[$];

  image_streamer #(.NUM_PIXELS(NP), .INPUT_SIZE(1)) u_s1 (
    .clock(clock), .reset(reset),
    .in_pixel(in_pixel_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .label_ready(label_ready_v[0]), .image_ready(image_ready_v[0]),
    .pixels(pix_a), .busy(busy_v[0]),
`ifdef IMAGE_STREAMER_TIMEOUT_EN
    .timeout(timeout_v[0]),
`endif
    .state_dbg(state_v[0])
  );

  image_streamer #(.NUM_PIXELS(NP), .INPUT_SIZE(4)) u_s4 (
    .clock(clock), .reset(reset),
    .in_pixel(in_pixel_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .label_ready(label_ready_v[1]), .image_ready(image_ready_v[1]),
    .pixels(pix_b), .busy(busy_v[1]),
`ifdef IMAGE_STREAMER_TIMEOUT_EN
    .timeout(timeout_v[1]),
`endif
    .state_dbg(state_v[1])
  );

  // ---------------- helpers ----------------
  function automatic int isz(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [MAXL*W-1:0] get_chunk(input int d);
    logic [MAXL*W-1:0] v;
    v = '0;
    if (d == 0) v[W-1:0] = pix_a[0];
    else for (int l = 0; l < 4; l++) v[l*W +: W] = pix_b[l];
    return v;
  endfunction

  // Reference model: chunk c lane l carries pixel c*n+l, or 0 past the image.
  task automatic build_expected(input int d, input pixel_t img[NP]);
    int n;
    n = isz(d);
    exp_q.delete();
    for (int c = 0; c < (NP + n - 1) / n; c++) begin
      logic [MAXL*W-1:0] v;
      v = '0;
      for (int l = 0; l < n; l++) if (c * n + l < NP) v[l*W +: W] = img[c*n+l];
      exp_q.push_back(v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_image(input int d, input pixel_t img[NP], input int gap_pct,
                            output int last_acc);
    int idx, guard;
    idx = 0; guard = 0; last_acc = -1;
    while (idx < NP && guard < 300) begin
      @(negedge clock);
      guard++;
      checks++;
      if (image_ready_v[d] !== 1'b0) begin
        failures++; $display("FAIL load_no_burst[%0d]: image_ready=%b required 0", d, image_ready_v[d]);
      end
      if ($urandom_range(99) < gap_pct) begin
        in_valid_v[d] = 1'b0; in_pixel_v[d] = pixel_t'($urandom);
      end else begin
        in_valid_v[d] = 1'b1; in_pixel_v[d] = img[idx];
        if (in_ready_v[d]) begin idx++; last_acc = cyc; end
      end
    end
    checks++;
    if (idx != NP) begin
      failures++; $display("FAIL load_timeout[%0d]: accepted=%0d required %0d", d, idx, NP);
    end
    @(negedge clock);
    // Junk outside LOAD must be ignored.
    in_valid_v[d] = 1'($urandom_range(1)); in_pixel_v[d] = pixel_t'($urandom);
  endtask

  task automatic check_burst(input int d, input int last_acc);
    int seen, first, guard, nch;
    logic [MAXL*W-1:0] exp, got;
    seen = 0; first = -1; guard = 0; nch = (NP + isz(d) - 1) / isz(d);
    while (guard < 40) begin
      checks++;
      if (in_ready_v[d] !== 1'b0) begin
        failures++; $display("FAIL stream_in_ready[%0d]: in_ready=%b required 0", d, in_ready_v[d]);
      end
      if (image_ready_v[d] === 1'b1) begin
        seen++;
        if (first < 0) first = cyc;
        got = get_chunk(d);
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL extra_chunk[%0d]: got=%h required no chunk", d, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++; $display("FAIL chunk[%0d] #%0d: got=%h required %h", d, seen, got, exp);
          end
        end
        checks++;
        if (busy_v[d] !== 1'b1) begin
          failures++; $display("FAIL busy_stream[%0d]: busy=%b required 1", d, busy_v[d]);
        end
      end else if (seen > 0) begin
        break;
      end
      in_valid_v[d] = 1'($urandom_range(1)); in_pixel_v[d] = pixel_t'($urandom);
      @(negedge clock);
      guard++;
    end
    in_valid_v[d] = 1'b0;
    checks++;
    if (seen != nch) begin
      failures++; $display("FAIL chunk_count[%0d]: got=%0d required %0d", d, seen, nch);
    end
    checks++;
    if (first - last_acc != 2) begin
      failures++; $display("FAIL latency[%0d]: got=%0d required 2", d, first - last_acc);
    end
    checks++;
    if (get_chunk(d) !== '0 || state_v[d] !== WAIT_LABEL || busy_v[d] !== 1'b1) begin
      failures++;
      $display("FAIL post_burst[%0d]: pixels=%h state=%0d busy=%b required 0/%0d/1",
               d, get_chunk(d), state_v[d], busy_v[d], WAIT_LABEL);
    end
  endtask

  task automatic release_label(input int d, input bit held);
    int k;
    if (!held) begin
      k = $urandom_range(1, 5);
      repeat (k) begin
        @(negedge clock);
        checks++;
        if (in_ready_v[d] !== 1'b0 || image_ready_v[d] !== 1'b0 || state_v[d] !== WAIT_LABEL) begin
          failures++;
          $display("FAIL wait_label[%0d]: in_ready=%b image_ready=%b state=%0d required 0/0/%0d",
                   d, in_ready_v[d], image_ready_v[d], state_v[d], WAIT_LABEL);
        end
        in_valid_v[d] = 1'($urandom_range(1));
      end
      in_valid_v[d] = 1'b0;
      label_ready_v[d] = 1'b1;
    end
    @(negedge clock);
    label_ready_v[d] = 1'b0;
    checks++;
    if (in_ready_v[d] !== 1'b1 || state_v[d] !== LOAD || busy_v[d] !== 1'b0) begin
      failures++;
      $display("FAIL release[%0d]: in_ready=%b state=%0d busy=%b required 1/%0d/0",
               d, in_ready_v[d], state_v[d], busy_v[d], LOAD);
    end
  endtask

  task automatic run_image(input int d, input pixel_t img[NP], input int gap_pct, input bit held);
    int last_acc;
    build_expected(d, img);
    label_ready_v[d] = held;
    load_image(d, img, gap_pct, last_acc);
    check_burst(d, last_acc);
    release_label(d, held);
  endtask

  task automatic random_image(output pixel_t img[NP]);
    for (int i = 0; i < NP; i++) img[i] = pixel_t'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid_v[d] = 1'b0; label_ready_v[d] = 1'b0; in_pixel_v[d] = '0;
    end
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_v[d] !== 1'b0 || image_ready_v[d] !== 1'b0 || busy_v[d] !== 1'b0 ||
          state_v[d] !== LOAD || get_chunk(d) !== '0) begin
        failures++;
        $display("FAIL reset_state[%0d]: in_ready=%b image_ready=%b busy=%b state=%0d pixels=%h required 0/0/0/%0d/0",
                 d, in_ready_v[d], image_ready_v[d], busy_v[d], state_v[d], get_chunk(d), LOAD);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_v[d] !== 1'b1) begin
        failures++; $display("FAIL reset_release[%0d]: in_ready=%b required 1", d, in_ready_v[d]);
      end
    end
  endtask

  task automatic test_ramp();
    pixel_t img[NP];
    for (int i = 0; i < NP; i++) img[i] = pixel_t'(i << FRACTION_WIDTH);
    run_image(0, img, 0, 1'b0);
    for (int i = 0; i < NP; i++) img[i] = pixel_t'((i + 1) << FRACTION_WIDTH);
    run_image(1, img, 0, 1'b0);
  endtask

  task automatic test_label_held();
    pixel_t img[NP];
    for (int d = 0; d < 2; d++) begin
      random_image(img);
      run_image(d, img, 0, 1'b1);
    end
  endtask

  task automatic test_gapped_load();
    pixel_t img[NP];
    for (int d = 0; d < 2; d++) begin
      random_image(img);
      run_image(d, img, 40, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    pixel_t img[NP];
    for (int n = 0; n < 6; n++) begin
      random_image(img);
      run_image(n % 2, img, $urandom_range(0, 30), 1'($urandom_range(1)));
    end
  endtask

  task automatic test_reset_mid_stream();
    pixel_t img[NP];
    int last_acc, seen, guard;
    random_image(img);
    build_expected(0, img);
    load_image(0, img, 0, last_acc);
    in_valid_v[0] = 1'b0;
    seen = 0; guard = 0;
    while (seen < 5 && guard < 40) begin
      if (image_ready_v[0] === 1'b1) seen++;
      if (seen < 5) begin @(negedge clock); guard++; end
    end
    checks++;
    if (seen != 5) begin
      failures++; $display("FAIL midstream_reach: chunks=%0d required 5", seen);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (image_ready_v[0] !== 1'b0 || get_chunk(0) !== '0 || busy_v[0] !== 1'b0 || state_v[0] !== LOAD) begin
      failures++;
      $display("FAIL midstream_reset: image_ready=%b pixels=%h busy=%b state=%0d required 0/0/0/%0d",
               image_ready_v[0], get_chunk(0), busy_v[0], state_v[0], LOAD);
    end
    @(negedge clock);
    reset = 1'b1;
    random_image(img);
    run_image(0, img, 20, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_label_held();
    test_gapped_load();
    test_back_to_back();
    test_reset_mid_stream();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
